// File: rtl/fpm_pkg.sv
// fpm_pkg: shared types and constants for the fused FP multiplier
// exponent path (sequencer states, accumulator width, bias values).
package fpm_pkg;

  localparam int ACC_W = 10;
  localparam int EXP_BIAS = 127;
  localparam logic [ACC_W-1:0] EXP_NEG_BIAS = 10'h381;
  localparam int EXP_MAX = 255;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_BIAS,
    S_NORM,
    S_DONE
  } exp_seq_state_t;

endpackage

// File: rtl/fpm_exp_add10.sv
// fpm_exp_add10: the single shared 10-bit wrapping adder of the
// exponent sequencer. Ports: op_a_i, op_b_i -> sum_o.
module fpm_exp_add10
  import fpm_pkg::*;
(
  input  logic [ACC_W-1:0] op_a_i,
  input  logic [ACC_W-1:0] op_b_i,
  output logic [ACC_W-1:0] sum_o
);

  assign sum_o = op_a_i + op_b_i;

endmodule

// File: rtl/fpm_exp_seq.sv
// fpm_exp_seq: multi-cycle exponent sequencer, ea + eb - BIAS (+ norm),
// saturated to 8 bits with ovf/unf flags, valid/ready on both sides.
// Ports: clk, rst_n (async low); start_valid/start_ready, ea, eb, norm
// in; res_valid/res_ready, exp_out, ovf, unf out.
// Optional NORM step enabled by defining FPM_EXP_SEQ_NORM_EN.
module fpm_exp_seq
  import fpm_pkg::*;
#(
  parameter int BIAS = EXP_BIAS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic [7:0] ea,
  input  logic [7:0] eb,
  input  logic       norm,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] exp_out,
  output logic       ovf,
  output logic       unf
);

  localparam logic [ACC_W-1:0] NEG_B = ACC_W'(-BIAS);
  localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(EXP_MAX);
  localparam logic signed [ACC_W-1:0] ZERO_S = '0;

  exp_seq_state_t state_q, state_d;
  logic [7:0] ea_q, eb_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0] exp_q, exp_d;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
  logic [ACC_W-1:0] op_a, op_b, sum;
  logic signed [ACC_W-1:0] sum_s;
  logic accept, load;

`ifdef FPM_EXP_SEQ_NORM_EN
  logic norm_q;
`else
  logic unused_norm;
  assign unused_norm = norm;
`endif

  assign start_ready = (state_q == S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign accept = start_valid && start_ready;

  assign exp_out = exp_q;
  assign ovf = ovf_q;
  assign unf = unf_q;

  fpm_exp_add10 u_add (
    .op_a_i (op_a),
    .op_b_i (op_b),
    .sum_o  (sum)
  );

  assign sum_s = sum;
  assign ovf_d = (sum_s >= MAX_S);
  assign unf_d = (sum_s <= ZERO_S);
  assign exp_d = ovf_d ? 8'hFF :
                 unf_d ? 8'h00 : sum[7:0];

  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    op_a = '0;
    op_b = '0;
    load = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_valid) state_d = S_ADD;
      end
      S_ADD: begin
        op_a = {2'b0, ea_q};
        op_b = {2'b0, eb_q};
        acc_d = sum;
        state_d = S_BIAS;
      end
      S_BIAS: begin
        op_a = acc_q;
        op_b = NEG_B;
        acc_d = sum;
`ifdef FPM_EXP_SEQ_NORM_EN
        state_d = S_NORM;
`else
        state_d = S_DONE;
        load = 1'b1;
`endif
      end
      S_NORM: begin
`ifdef FPM_EXP_SEQ_NORM_EN
        op_a = acc_q;
        op_b = {{(ACC_W-1){1'b0}}, norm_q};
        acc_d = sum;
        state_d = S_DONE;
        load = 1'b1;
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ea_q <= '0;
      eb_q <= '0;
      acc_q <= '0;
      exp_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      if (accept) begin
        ea_q <= ea;
        eb_q <= eb;
      end
      if (load) begin
        exp_q <= exp_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
      end
    end
  end

`ifdef FPM_EXP_SEQ_NORM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) norm_q <= 1'b0;
    else if (accept) norm_q <= norm;
  end
`endif

endmodule

// File: tb/tb_fpm_exp_seq.sv
// tb_fpm_exp_seq: scoreboard bench for fpm_exp_seq; directed vectors,
// expected results queued at issue and checked by a separate monitor.
module tb_fpm_exp_seq;

`ifdef FPM_EXP_SEQ_NORM_EN
  localparam int LAT = 3;
  localparam bit NORM_EN = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit NORM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_valid = 1'b0;
  logic start_ready;
  logic [7:0] ea = '0;
  logic [7:0] eb = '0;
  logic norm = 1'b0;
  logic res_valid;
  logic res_ready = 1'b1;
  logic [7:0] exp_out;
  logic ovf;
  logic unf;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] ex;
    logic ov;
    logic un;
    int acc_c;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic n;
    logic [7:0] ex0;
    logic ov0;
    logic un0;
    logic [7:0] ex1;
    logic ov1;
    logic un1;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  fpm_exp_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .ea          (ea),
    .eb          (eb),
    .norm        (norm),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .exp_out     (exp_out),
    .ovf         (ovf),
    .unf         (unf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at cycle %0d",
               name, act, req, cyc);
    end
  endtask

  logic prev_v = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && res_valid && !prev_v && sb.size() > 0)
      check("latency", cyc - sb[0].acc_c, LAT);
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("unexpected result", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result {exp,ovf,unf}",
              {22'd0, exp_out, ovf, unf},
              {22'd0, e.ex, e.ov, e.un});
      end
    end
    prev_v <= res_valid;
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic n, output int acc_c);
    int t;
    t = 0;
    @(negedge clk);
    while (!start_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!start_ready) check("start_ready timeout", 32'd0, 32'd1);
    ea = a;
    eb = b;
    norm = n;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    acc_c = cyc;
  endtask

  task automatic run(input vec_t v);
    exp_t e;
    int c;
    issue(v.a, v.b, v.n, c);
    e.ex = NORM_EN ? v.ex1 : v.ex0;
    e.ov = NORM_EN ? v.ov1 : v.ov0;
    e.un = NORM_EN ? v.un1 : v.un0;
    e.acc_c = c;
    sb.push_back(e);
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!res_valid && t < 50);
    if (!res_valid) check("res_valid timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard drained", sb.size(), 0);
  endtask

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b,
                              input logic n, input logic [7:0] x0,
                              input logic o0, input logic u0,
                              input logic [7:0] x1, input logic o1,
                              input logic u1);
    vec_t v;
    v.a = a; v.b = b; v.n = n;
    v.ex0 = x0; v.ov0 = o0; v.un0 = u0;
    v.ex1 = x1; v.ov1 = o1; v.un1 = u1;
    return v;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s_exp;
    logic s_ovf, s_unf;
    int c;

    vecs.push_back(mk(8'd200, 8'd200, 1'b0, 8'hFF, 1, 0, 8'hFF, 1, 0));
    vecs.push_back(mk(8'd50,  8'd60,  1'b0, 8'h00, 0, 1, 8'h00, 0, 1));
    vecs.push_back(mk(8'd64,  8'd63,  1'b0, 8'h00, 0, 1, 8'h00, 0, 1));
    vecs.push_back(mk(8'd127, 8'd128, 1'b1, 8'd128, 0, 0, 8'd129, 0, 0));
    vecs.push_back(mk(8'd254, 8'd127, 1'b1, 8'd254, 0, 0, 8'hFF, 1, 0));
    vecs.push_back(mk(8'd255, 8'd127, 1'b0, 8'hFF, 1, 0, 8'hFF, 1, 0));
    vecs.push_back(mk(8'd128, 8'd0,   1'b0, 8'd1, 0, 0, 8'd1, 0, 0));
    vecs.push_back(mk(8'd0,   8'd0,   1'b1, 8'h00, 0, 1, 8'h00, 0, 1));
    vecs.push_back(mk(8'd255, 8'd255, 1'b1, 8'hFF, 1, 0, 8'hFF, 1, 0));
    vecs.push_back(mk(8'd127, 8'd127, 1'b1, 8'd127, 0, 0, 8'd128, 0, 0));
    vecs.push_back(mk(8'd253, 8'd128, 1'b1, 8'd254, 0, 0, 8'hFF, 1, 0));
    vecs.push_back(mk(8'd1,   8'd127, 1'b0, 8'd1, 0, 0, 8'd1, 0, 0));

    @(negedge clk);
    check("reset start_ready", start_ready, 1);
    check("reset res_valid", res_valid, 0);
    check("reset exp_out", exp_out, 0);
    check("reset ovf", ovf, 0);
    check("reset unf", unf, 0);
    rst_n = 1'b1;

    run(mk(8'd127, 8'd127, 1'b0, 8'd127, 0, 0, 8'd127, 0, 0));
    wait_valid();
    @(negedge clk);
    check("idle after done start_ready", start_ready, 1);
    check("idle after done res_valid", res_valid, 0);

    foreach (vecs[i]) run(vecs[i]);
    drain();

    res_ready = 1'b0;
    run(mk(8'd100, 8'd100, 1'b0, 8'd73, 0, 0, 8'd73, 0, 0));
    wait_valid();
    s_exp = exp_out;
    s_ovf = ovf;
    s_unf = unf;
    check("hold first exp_out", s_exp, 8'd73);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("hold res_valid", res_valid, 1);
      check("hold start_ready", start_ready, 0);
      check("hold outputs stable", {exp_out, ovf, unf},
            {s_exp, s_ovf, s_unf});
      start_valid = 1'b1;
      ea = 8'hAA;
      eb = 8'hAA;
    end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    res_ready = 1'b1;
    drain();

    run(mk(8'd255, 8'd255, 1'b0, 8'hFF, 1, 0, 8'hFF, 1, 0));
    drain();

    issue(8'd200, 8'd10, 1'b0, c);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort res_valid", res_valid, 0);
    check("abort start_ready", start_ready, 1);
    check("abort exp_out", exp_out, 0);
    check("abort ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(mk(8'd130, 8'd127, 1'b0, 8'd130, 0, 0, 8'd130, 0, 0));
    drain();

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
